fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_buffer.sv | 63 ++++++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The queue entry is the fetched word plus the PC+4 that decode needs for links/branches.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam int          ENTRY_W          = 64;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus_4;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO between fetch and decode; flush empties it and
// overrides any push or pop presented in the same cycle.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [1:0]         count_o,
    output logic [ENTRY_W-1:0] head_o
);

    logic [ENTRY_W-1:0] mem_q [2];
    logic [ENTRY_W-1:0] mem_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               push_en, pop_en;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_en   = pop_i && !flush_i && (count_q != 2'd0);
        push_en  = push_i && !flush_i && ((count_q != 2'd2) || pop_en);
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_en) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {1'b0, push_en} - {1'b0, pop_en};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to a
// handshaked instruction memory and queues responses for decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
)(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_plus_4_o
);

    localparam logic [1:0] DEPTH_CNT = 2'(BUF_DEPTH);

    fetch_state_e state_q, state_d, rst_state;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tag_q, tag_d;
    logic         handshake;
    logic         buf_push, buf_pop;
    logic [1:0]   buf_count;
    fetch_entry_t push_entry, head_entry;

    always_comb begin
        imem_req_o           = reset && (state_q == ST_FETCH) && (buf_count < DEPTH_CNT);
        imem_addr_o          = pc_q;
        handshake            = imem_req_o && imem_ready_i;
        buf_push             = (state_q == ST_WAIT) && imem_rvalid_i;
        push_entry.instr     = imem_rdata_i;
        push_entry.pc_plus_4 = tag_q;
        if_valid_o           = (buf_count != 2'd0);
        buf_pop              = if_valid_o && id_ready_i;
        if_instr_o           = if_valid_o ? head_entry.instr : NOP_INSTR;
        if_pc_plus_4_o       = if_valid_o ? head_entry.pc_plus_4 : 32'h0;

        state_d = state_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        case (state_q)
            ST_FETCH: begin
                if (handshake) begin
                    pc_d    = pc_q + 32'd4;
                    tag_d   = pc_q + 32'd4;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT:  if (imem_rvalid_i) state_d = ST_FETCH;
            ST_FLUSH: if (imem_rvalid_i) state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase

        // A request still in flight after a redirect must be swallowed in FLUSH.
        if (redirect_valid_i) begin
            pc_d = align_word(redirect_pc_i);
            if (state_q == ST_FETCH) begin
                state_d = handshake ? ST_FLUSH : ST_FETCH;
            end else begin
                state_d = imem_rvalid_i ? ST_FETCH : ST_FLUSH;
            end
        end

        if ((state_q == ST_WAIT) || (state_q == ST_FLUSH)) begin
            rst_state = ST_FLUSH;
        end else begin
            rst_state = ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= rst_state;
            pc_q    <= RESET_PC;
            tag_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
        end
    end

    fetch_buffer u_buffer (
        .clk         (clk),
        .reset       (reset),
        .push_i      (buf_push),
        .push_data_i (push_entry),
        .pop_i       (buf_pop),
        .flush_i     (redirect_valid_i),
        .count_o     (buf_count),
        .head_o      (head_entry)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural memory plus a scoreboard
// queue of expected decode entries, compared every cycle.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_plus_4_o;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ready_i     (imem_ready_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .id_ready_i       (id_ready_i),
        .if_valid_o       (if_valid_o),
        .if_instr_o       (if_instr_o),
        .if_pc_plus_4_o   (if_pc_plus_4_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_pc   = RST_PC;
    logic        pend       = 1'b0;
    logic        pend_stale = 1'b0;
    logic [31:0] pend_addr  = 32'h0;
    logic [31:0] pend_pc4   = 32'h0;
    int          pend_cnt   = 0;
    int          mem_lat    = 1;
    int          hs_count   = 0;
    bit          chk_en     = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive memory response, check outputs, then advance the model at the edge.
    task automatic cycle();
        logic        exp_req, hs, rv, pop, redir, rst_n;
        logic [31:0] addr, tgt;
        exp_t        ent;
        imem_rvalid_i = pend && (pend_cnt == 0);
        imem_rdata_i  = imem_rvalid_i ? mem_word(pend_addr) : 32'hBAD0_BAD0;
        #1;
        exp_req = reset && !pend && (exp_q.size() < 2);
        if (chk_en) begin
            check_eq("imem_req", imem_req_o, exp_req);
            if (exp_req) check_eq("imem_addr", imem_addr_o, exp_pc);
            check_eq("if_valid", if_valid_o, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check_eq("if_instr", if_instr_o, exp_q[0].instr);
                check_eq("if_pc_plus_4", if_pc_plus_4_o, exp_q[0].pc4);
            end else begin
                check_eq("if_instr_nop", if_instr_o, 32'h0);
                check_eq("if_pc_plus_4_zero", if_pc_plus_4_o, 32'h0);
            end
        end
        hs    = imem_req_o && imem_ready_i;
        addr  = imem_addr_o;
        rv    = imem_rvalid_i;
        pop   = (exp_q.size() != 0) && id_ready_i;
        redir = redirect_valid_i;
        tgt   = redirect_pc_i;
        rst_n = reset;
        @(posedge clk);
        if (rv) pend = 1'b0;
        else if (pend) pend_cnt--;
        if (!rst_n) begin
            exp_q.delete();
            exp_pc = RST_PC;
            if (pend) pend_stale = 1'b1;
        end else begin
            if (pop && !redir) begin
                $display("pop instr=%h pc_plus_4=%h", exp_q[0].instr, exp_q[0].pc4);
                void'(exp_q.pop_front());
            end
            if (rv && !pend_stale && !redir) begin
                ent.instr = mem_word(pend_addr);
                ent.pc4   = pend_pc4;
                exp_q.push_back(ent);
            end
            if (hs) begin
                hs_count++;
                pend       = 1'b1;
                pend_addr  = addr;
                pend_cnt   = mem_lat - 1;
                pend_stale = redir;
                exp_pc     = exp_pc + 32'd4;
                pend_pc4   = exp_pc;
            end
            if (redir) begin
                exp_q.delete();
                exp_pc = tgt & 32'hFFFF_FFFC;
                if (pend && !hs) pend_stale = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic redirect_once(input logic [31:0] tgt);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = tgt;
        cycle();
        redirect_valid_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        imem_ready_i     = 1'b1;
        imem_rvalid_i    = 1'b0;
        imem_rdata_i     = 32'h0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        id_ready_i       = 1'b1;
        @(negedge clk);
        cycle();
        chk_en = 1'b1;
        repeat (2) cycle();
        reset = 1'b1;

        // Stall decode: queue fills with the first two words, then drains in order.
        mem_lat    = 1;
        id_ready_i = 1'b0;
        hs_count   = 0;
        repeat (10) cycle();
        check_eq("stall_reqs", hs_count, 2);
        check_eq("stall_head_pc4", if_pc_plus_4_o, 32'h0040_0004);
        check_eq("stall_head_instr", if_instr_o, mem_word(RST_PC));
        id_ready_i = 1'b1;
        repeat (8) cycle();

        // Redirect while a slow response is outstanding.
        mem_lat = 3;
        for (int i = 0; i < 20 && !(pend && pend_cnt == 2); i++) cycle();
        check_eq("wait_pend_wait", pend, 1'b1);
        redirect_once(32'h0040_0100);
        repeat (10) cycle();

        // Redirect coinciding with a response and a pop.
        mem_lat    = 1;
        id_ready_i = 1'b0;
        for (int i = 0; i < 30 && !(exp_q.size() == 1 && pend && pend_cnt == 0); i++) cycle();
        check_eq("wait_rv_pop", exp_q.size() == 1 && pend && pend_cnt == 0, 1'b1);
        id_ready_i = 1'b1;
        redirect_once(32'h0040_0300);
        check_eq("redir_flush_valid", if_valid_o, 1'b0);
        check_eq("redir_flush_instr", if_instr_o, 32'h0);
        repeat (6) cycle();

        // Unaligned redirect target and PC wrap at the top of the address space.
        for (int i = 0; i < 20 && pend; i++) cycle();
        redirect_once(32'h0040_0203);
        check_eq("redir_align_addr", imem_addr_o, 32'h0040_0200);
        repeat (6) cycle();
        redirect_once(32'hFFFF_FFF8);
        repeat (10) cycle();

        // Reset while a request is outstanding; its late response must be dropped.
        mem_lat = 5;
        for (int i = 0; i < 30 && !(pend && pend_cnt == 4); i++) cycle();
        check_eq("wait_pend_reset", pend, 1'b1);
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() == 0; i++) cycle();
        check_eq("post_reset_pc4", if_pc_plus_4_o, RST_PC + 32'd4);
        check_eq("post_reset_instr", if_instr_o, mem_word(RST_PC));

        // Random traffic: memory backpressure, latencies, decode stalls, redirects.
        for (int i = 0; i < 400; i++) begin
            imem_ready_i = ($urandom_range(0, 3) != 0);
            id_ready_i   = ($urandom_range(0, 2) != 0);
            mem_lat      = $urandom_range(1, 3);
            if ($urandom_range(0, 15) == 0) begin
                redirect_once(32'h0040_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3));
            end else begin
                cycle();
            end
        end
        imem_ready_i = 1'b1;
        id_ready_i   = 1'b1;
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
